// File: rtl/fabric_arb_pkg.sv
// rtl/fabric_arb_pkg.sv - FSM state encoding and port-index width helper for the fabric ingress arbiter
package fabric_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   function automatic int port_bits(input int num_ports);
      return (num_ports <= 1) ? 1 : $clog2(num_ports);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick: first requester at or after rr_ptr, wrapping
module rr_priority_select
   import fabric_arb_pkg::*;
#(
   parameter int NUM_PORTS = 24,
   parameter int PORT_BITS = port_bits(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_BITS-1:0] rr_ptr,
   output logic                 hit,
   output logic [PORT_BITS-1:0] index
);

   logic [PORT_BITS-1:0] cand;

   always_comb begin
      hit   = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = PORT_BITS'((int'(rr_ptr) + i) % NUM_PORTS);
         if (!hit && req[cand]) begin
            hit   = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fabric_ingress_arbiter.sv
// rtl/fabric_ingress_arbiter.sv - round-robin frame arbiter merging line-card streams into one fabric stream
// Optional frame-length watchdog enabled by FABRIC_ARB_WATCHDOG_EN.
module fabric_ingress_arbiter
   import fabric_arb_pkg::*;
#(
   parameter int  NUM_PORTS       = 24,
   parameter int  DATA_WIDTH      = 32,
   parameter int  MAX_FRAME_BEATS = 512,
   localparam int PORT_BITS       = port_bits(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            in_tvalid,
   input  logic [NUM_PORTS-1:0]            in_tlast,
   input  logic [NUM_PORTS-1:0]            in_tuser,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
   output logic [NUM_PORTS-1:0]            in_tready,
   output logic                            out_tvalid,
   output logic                            out_tlast,
   output logic                            out_tuser,
   output logic [DATA_WIDTH-1:0]           out_tdata,
   input  logic                            out_tready,
   output logic [PORT_BITS-1:0]            out_tid,
   output logic                            wd_abort
);

   if (NUM_PORTS < 1 || NUM_PORTS > 32 || MAX_FRAME_BEATS < 1) begin : g_bad_cfg
      $error("fabric_ingress_arbiter: illegal parameter set");
   end

   logic [DATA_WIDTH-1:0] in_data_arr [NUM_PORTS];
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign in_data_arr[p] = in_tdata[p*DATA_WIDTH +: DATA_WIDTH];
   end

   arb_state_e            state_q, state_d;
   logic [PORT_BITS-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PORT_BITS-1:0]  grant_q, grant_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic                  out_tlast_q, out_tlast_d;
   logic                  out_tuser_q, out_tuser_d;
   logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
   logic [PORT_BITS-1:0]  out_tid_q, out_tid_d;
   logic                  wd_abort_q, wd_abort_d;
`ifdef FABRIC_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
`endif

   logic                  sel_hit;
   logic [PORT_BITS-1:0]  sel_idx;
   logic [NUM_PORTS-1:0]  ready_vec;
   logic                  out_free;
   logic                  accept;
   logic [PORT_BITS-1:0]  next_ptr;

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_BITS (PORT_BITS)
   ) u_rr_select (
      .req    (in_tvalid),
      .rr_ptr (rr_ptr_q),
      .hit    (sel_hit),
      .index  (sel_idx)
   );

   assign out_free = !out_tvalid_q || out_tready;
   assign next_ptr = (grant_q == PORT_BITS'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

   // ABORT sinks the rest of a truncated frame regardless of downstream backpressure
   always_comb begin
      ready_vec = '0;
      case (state_q)
         XFER:    ready_vec[grant_q] = out_free;
`ifdef FABRIC_ARB_WATCHDOG_EN
         ABORT:   ready_vec[grant_q] = 1'b1;
`endif
         default: ready_vec = '0;
      endcase
   end

   assign in_tready = ready_vec;
   assign accept    = ready_vec[grant_q] & in_tvalid[grant_q];

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      out_tvalid_d = out_tvalid_q && !out_tready;
      out_tlast_d  = out_tlast_q;
      out_tuser_d  = out_tuser_q;
      out_tdata_d  = out_tdata_q;
      out_tid_d    = out_tid_q;
      wd_abort_d   = 1'b0;
`ifdef FABRIC_ARB_WATCHDOG_EN
      beat_cnt_d   = beat_cnt_q;
`endif
      if (state_q == XFER && accept) begin
         out_tvalid_d = 1'b1;
         out_tdata_d  = in_data_arr[grant_q];
         out_tlast_d  = in_tlast[grant_q];
         out_tuser_d  = in_tuser[grant_q];
         out_tid_d    = grant_q;
      end
      case (state_q)
         IDLE: begin
            if (sel_hit) begin
               grant_d = sel_idx;
               state_d = XFER;
`ifdef FABRIC_ARB_WATCHDOG_EN
               beat_cnt_d = '0;
`endif
            end
         end
         XFER: begin
            if (accept) begin
`ifdef FABRIC_ARB_WATCHDOG_EN
               beat_cnt_d = beat_cnt_q + 1'b1;
`endif
               if (in_tlast[grant_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
`ifdef FABRIC_ARB_WATCHDOG_EN
               end else if (beat_cnt_q == CNT_W'(MAX_FRAME_BEATS - 1)) begin
                  out_tlast_d = 1'b1;
                  out_tuser_d = 1'b1;
                  wd_abort_d  = 1'b1;
                  state_d     = ABORT;
`endif
               end
            end
         end
`ifdef FABRIC_ARB_WATCHDOG_EN
         ABORT: begin
            if (accept && in_tlast[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
         out_tuser_q  <= 1'b0;
         out_tdata_q  <= '0;
         out_tid_q    <= '0;
         wd_abort_q   <= 1'b0;
`ifdef FABRIC_ARB_WATCHDOG_EN
         beat_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         out_tvalid_q <= out_tvalid_d;
         out_tlast_q  <= out_tlast_d;
         out_tuser_q  <= out_tuser_d;
         out_tdata_q  <= out_tdata_d;
         out_tid_q    <= out_tid_d;
         wd_abort_q   <= wd_abort_d;
`ifdef FABRIC_ARB_WATCHDOG_EN
         beat_cnt_q   <= beat_cnt_d;
`endif
      end
   end

   assign out_tvalid = out_tvalid_q;
   assign out_tlast  = out_tlast_q;
   assign out_tuser  = out_tuser_q;
   assign out_tdata  = out_tdata_q;
   assign out_tid    = out_tid_q;
   assign wd_abort   = wd_abort_q;

endmodule

// File: doc/fabric_ingress_arbiter.md
FABRIC_INGRESS_ARBITER -- requirements
Module: fabric_ingress_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 24: number of line card ingress streams; legal range 1..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: tdata width per stream.
REQ-003 SHALL have parameter MAX_FRAME_BEATS, default 512: watchdog beat limit per frame.
REQ-004 SHALL have port clk  in  1: single clock (clk_fabric domain); all logic is synchronous to it.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have ports in_tvalid / in_tlast / in_tuser  in  NUM_PORTS each: per-port AXI-Stream controls.
REQ-007 SHALL have port in_tdata  in  NUM_PORTS x DATA_WIDTH: per-port data, packed with port 0 in the LSBs.
REQ-008 SHALL have port in_tready  out  NUM_PORTS: per-port ready, one-hot or zero.
REQ-009 SHALL have ports out_tvalid / out_tlast / out_tuser  out  1 each, and out_tdata  out  DATA_WIDTH: the merged stream to the fabric.
REQ-010 SHALL have port out_tready  in  1: downstream ready.
REQ-011 SHALL have port out_tid  out  PORT_BITS = max(1, clog2(NUM_PORTS)): source port of the current out beat.
REQ-012 SHALL have port wd_abort  out  1: one-cycle pulse when the watchdog truncates a frame.

Function
REQ-013 SHALL implement FSM states IDLE, XFER and ABORT.
REQ-014 In IDLE, SHALL select the lowest index >= rr_ptr with in_tvalid set, wrapping modulo NUM_PORTS; SHALL latch it as grant and enter XFER the next cycle; SHALL assert no in_tready in IDLE.
REQ-015 In XFER, in_tready[grant] SHALL equal (!out_tvalid || out_tready); all other in_tready bits SHALL be 0.
REQ-016 SHALL register the output: an accepted input beat appears on out_* the next cycle (latency 1), with out_tid = grant.
REQ-017 SHALL hold out_* stable while out_tvalid && !out_tready; out_tvalid SHALL deassert only after acceptance with no new beat loaded.
REQ-018 SHALL hold the grant while the granted port deasserts tvalid mid-frame; no other port is served.
REQ-019 On accepting a beat with tlast, SHALL enter IDLE and set rr_ptr = (grant+1) mod NUM_PORTS.
REQ-020 SHALL handle a single-beat frame as a full frame; minimum frame-to-frame cost is one IDLE cycle.
REQ-021 SHALL count accepted beats per frame in a counter of width clog2(MAX_FRAME_BEATS+1); the counter clears on entry to XFER.
REQ-022 SHALL serve a lone active requester back-to-back, re-granting it after each IDLE cycle.

Reset
REQ-023 On rst_n low, SHALL set state IDLE, rr_ptr 0, grant 0, beat count 0, out_tvalid/out_tlast/out_tuser 0, out_tid 0, wd_abort 0, and in_tready 0, immediately and asynchronously.
REQ-024 On reset mid-frame, SHALL discard the partial frame; after reset release, arbitration restarts from port 0.

Configuration
REQ-025 SHALL gate the watchdog with macro FABRIC_ARB_WATCHDOG_EN.
REQ-026 With FABRIC_ARB_WATCHDOG_EN defined, beat MAX_FRAME_BEATS without tlast SHALL be forwarded with out_tlast=1 and out_tuser=1, and wd_abort SHALL pulse.
REQ-027 With FABRIC_ARB_WATCHDOG_EN defined, after the truncating beat the FSM SHALL enter ABORT, hold in_tready[grant]=1, and discard beats until tlast; it SHALL then enter IDLE and advance rr_ptr.
REQ-028 Without FABRIC_ARB_WATCHDOG_EN, SHALL omit ABORT and the beat counter, and tie wd_abort to 0; frames are unbounded.

Structure
REQ-029 SHALL place the FSM state enum and the PORT_BITS width function in package fabric_arb_pkg.
REQ-030 SHALL implement round-robin selection in combinational sub-module rr_priority_select (inputs: request vector, rr_ptr; outputs: hit, index).

Verification
REQ-031 Ports 3, 7 and 20 each offer one 4-beat frame at t0, rr_ptr=0 -> output order 3, 7, 20; out_tid matches each beat; 12 beats total.
REQ-032 Port 5 sends a 1-beat frame while out_tready toggles 1,0,1 -> out beat held stable for 2 cycles; single acceptance; rr_ptr=6.
REQ-033 Port 23 granted and rr_ptr wraps; ports 0 and 22 then request -> port 0 is served before port 22.
REQ-034 With the watchdog enabled and MAX_FRAME_BEATS=8, port 2 sends a 12-beat frame -> 8 beats forwarded, beat 8 has tlast=1 and tuser=1, wd_abort pulses once, 4 beats are discarded, then IDLE.
REQ-035 Port 9 drops tvalid for 5 cycles mid-frame while port 10 requests -> no port-10 beat appears until port 9's tlast is accepted.
REQ-036 rst_n asserted in beat 3 of an 8-beat frame -> out_tvalid=0 in the same cycle; after release, the next grant comes from the lowest requesting port.
